// File: rtl/a78_pkg.sv
// Shared A78 cartridge definitions: header byte offsets, the "ATARI" magic
// and the loader state encoding.
package a78_pkg;
  localparam int MAGIC_LO = 1;
  localparam int MAGIC_HI = 5;
  localparam int SIZE_B0  = 49;
  localparam int FLAGS_HI = 53;
  localparam int FLAGS_LO = 54;
  localparam int JOY0     = 55;
  localparam int JOY1     = 56;
  localparam int REGION   = 57;
  localparam int SAVE     = 58;

  localparam logic [39:0] MAGIC = "ATARI";

  typedef enum logic [1:0] {IDLE, HEADER, BODY, FINISH} load_state_e;

  // Magic character expected at a header offset in MAGIC_LO..MAGIC_HI.
  function automatic logic [7:0] magic_byte(input int offset);
    return MAGIC[8*(MAGIC_HI - offset) +: 8];
  endfunction
endpackage

// File: rtl/a78_hdr_parse.sv
// A78 header capture: magic match and descriptor fields, written by any
// accepted byte below HDR_LEN. hdr_size exists only with A78_HDR_SIZE_EN.
module a78_hdr_parse
  import a78_pkg::*;
#(
  parameter int HDR_LEN = 128
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        clear,
  input  logic        wr,
  input  logic [24:0] addr,
  input  logic [7:0]  data,
  output logic        is_7800,
  output logic [15:0] flags,
  output logic [7:0]  joy0_type,
  output logic [7:0]  joy1_type,
  output logic [7:0]  region,
  output logic [7:0]  save
`ifdef A78_HDR_SIZE_EN
  ,
  output logic [31:0] hdr_size
`endif
);
  localparam logic [24:0] HDR_L = 25'(HDR_LEN);

  logic [4:0] match;
  logic [4:0] match_next;
  logic       hdr_wr;

  assign hdr_wr = wr && (addr < HDR_L);

  // A clear and a capture in the same cycle keep the captured byte.
  always_comb begin
    match_next = clear ? 5'd0 : match;
    for (int i = 0; i < 5; i++) begin
      if (hdr_wr && (addr == 25'(MAGIC_LO + i)))
        match_next[i] = (data == magic_byte(MAGIC_LO + i));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      match     <= '0;
      is_7800   <= 1'b0;
      flags     <= '0;
      joy0_type <= '0;
      joy1_type <= '0;
      region    <= '0;
      save      <= '0;
    end else begin
      match   <= match_next;
      is_7800 <= &match_next;
      if (clear) begin
        flags     <= '0;
        joy0_type <= '0;
        joy1_type <= '0;
        region    <= '0;
        save      <= '0;
      end
      if (hdr_wr) begin
        case (addr)
          25'(FLAGS_HI): flags[15:8] <= data;
          25'(FLAGS_LO): flags[7:0]  <= data;
          25'(JOY0):     joy0_type   <= data;
          25'(JOY1):     joy1_type   <= data;
          25'(REGION):   region      <= data;
          25'(SAVE):     save        <= data;
          default: ;
        endcase
      end
    end
  end

`ifdef A78_HDR_SIZE_EN
  // Declared ROM size, stored big-endian in the header.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hdr_size <= '0;
    end else begin
      if (clear) hdr_size <= '0;
      if (hdr_wr) begin
        case (addr)
          25'(SIZE_B0):     hdr_size[31:24] <= data;
          25'(SIZE_B0 + 1): hdr_size[23:16] <= data;
          25'(SIZE_B0 + 2): hdr_size[15:8]  <= data;
          25'(SIZE_B0 + 3): hdr_size[7:0]   <= data;
          default: ;
        endcase
      end
    end
  end
`endif
endmodule

// File: rtl/a78_cart_loader.sv
// Cart download front end: ioctl byte stream to header-stripped cart RAM writes,
// final size and power-on release. A78_HDR_SIZE_EN clamps size to the header value.
module a78_cart_loader
  import a78_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int HDR_LEN = 128
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cart_is_7800,
  output logic [15:0]       cart_flags,
  output logic [7:0]        joy0_type,
  output logic [7:0]        joy1_type,
  output logic [7:0]        cart_region,
  output logic [7:0]        cart_save,
  output logic [31:0]       cart_size,
  output logic              overflow,
  output logic              load_done,
  output logic              run_en,
  output load_state_e       load_state
);
  localparam logic [24:0] HDR_L    = 25'(HDR_LEN);
  localparam logic [25:0] ADDR_LIM = 26'(1) << ADDR_W;

  load_state_e state;
  load_state_e state_next;
  logic        cart_dl;
  logic        hold;
  logic        accept;
  logic        enter_hdr;
  logic        finishing;
  logic        drop;
  logic [24:0] off_addr;
  logic [24:0] last_addr;
  logic        seen;
  logic [31:0] total;
  logic [31:0] hdr_sub;
  logic [31:0] size_calc;
  logic [31:0] size_next;
`ifdef A78_HDR_SIZE_EN
  logic [31:0] hdr_size;
`endif

  assign cart_dl    = ioctl_download && (ioctl_index != 8'd0);
  assign load_state = state;

  // hold blocks a download that was already running across reset until it drops.
  // Writes pass on the rising-edge cycle and on the falling-edge cycle too.
  assign accept = ioctl_wr && (ioctl_index != 8'd0) &&
                  ((state == HEADER) || (state == BODY) || (ioctl_download && !hold));

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cart_dl && !hold) state_next = HEADER;
      HEADER: begin
        if (!cart_dl)                               state_next = FINISH;
        else if (accept && (ioctl_addr >= HDR_L))   state_next = BODY;
      end
      BODY:    if (!cart_dl) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    enter_hdr = (state == IDLE) && cart_dl && !hold;
    finishing = (state == FINISH);
    off_addr  = (cart_is_7800 && (ioctl_addr >= HDR_L)) ? (ioctl_addr - HDR_L) : ioctl_addr;
    drop      = ({1'b0, off_addr} >= ADDR_LIM);
    total     = {7'd0, last_addr} + 32'd1;
    hdr_sub   = cart_is_7800 ? 32'(HDR_LEN) : 32'd0;
    size_calc = (seen && (total > hdr_sub)) ? (total - hdr_sub) : 32'd0;
    size_next = size_calc;
`ifdef A78_HDR_SIZE_EN
    if (cart_is_7800 && (hdr_size != 32'd0) && (hdr_size < size_calc)) size_next = hdr_size;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold      <= cart_dl;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      overflow  <= 1'b0;
      last_addr <= '0;
      seen      <= 1'b0;
      cart_size <= '0;
      load_done <= 1'b0;
      run_en    <= 1'b0;
    end else begin
      if (!cart_dl) hold <= 1'b0;
      mem_we <= accept && !drop;
      if (accept && !drop) begin
        mem_addr <= off_addr[ADDR_W-1:0];
        mem_data <= ioctl_dout;
      end
      if (enter_hdr) begin
        overflow  <= 1'b0;
        last_addr <= '0;
        seen      <= 1'b0;
      end
      if (accept) begin
        last_addr <= ioctl_addr;
        seen      <= 1'b1;
        if (drop) overflow <= 1'b1;
      end
      load_done <= finishing;
      if (finishing) begin
        cart_size <= size_next;
        run_en    <= 1'b1;
      end
    end
  end

  a78_hdr_parse #(.HDR_LEN(HDR_LEN)) u_hdr (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clear     (enter_hdr),
    .wr        (accept),
    .addr      (ioctl_addr),
    .data      (ioctl_dout),
    .is_7800   (cart_is_7800),
    .flags     (cart_flags),
    .joy0_type (joy0_type),
    .joy1_type (joy1_type),
    .region    (cart_region),
    .save      (cart_save)
`ifdef A78_HDR_SIZE_EN
    ,
    .hdr_size  (hdr_size)
`endif
  );
endmodule

// File: tb/tb_a78_cart_loader.sv
// Bench for a78_cart_loader: image-level model of the RAM write stream and
// cart size, plus directed literal checks of header fields, timing and reset.
module tb_a78_cart_loader;
  import a78_pkg::*;

  localparam int ADDR_W  = 18;
  localparam int HDR_LEN = 128;
`ifdef A78_HDR_SIZE_EN
  localparam logic [31:0] A_SIZE = 32'd16384;
`else
  localparam logic [31:0] A_SIZE = 32'd32768;
`endif

  // clock / reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              cart_is_7800;
  logic [15:0]       cart_flags;
  logic [7:0]        joy0_type;
  logic [7:0]        joy1_type;
  logic [7:0]        cart_region;
  logic [7:0]        cart_save;
  logic [31:0]       cart_size;
  logic              overflow;
  logic              load_done;
  logic              run_en;
  load_state_e       load_state;

  a78_cart_loader #(.ADDR_W(ADDR_W), .HDR_LEN(HDR_LEN)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .cart_is_7800   (cart_is_7800),
    .cart_flags     (cart_flags),
    .joy0_type      (joy0_type),
    .joy1_type      (joy1_type),
    .cart_region    (cart_region),
    .cart_save      (cart_save),
    .cart_size      (cart_size),
    .overflow       (overflow),
    .load_done      (load_done),
    .run_en         (run_en),
    .load_state     (load_state)
  );

  // scoreboard / model state
  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [25:0] exp_q[$];
  logic [7:0]  hdr [HDR_LEN];
  bit          m_active;
  bit          m_7800;
  bit          m_seen;
  logic [24:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [24:0] a);
    if (a < 25'(HDR_LEN)) return hdr[a[6:0]];
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] model_size();
    longint s;
    if (!m_seen) return 32'd0;
    s = longint'(m_last) + 1 - (m_7800 ? HDR_LEN : 0);
    if (s < 0) s = 0;
`ifdef A78_HDR_SIZE_EN
    begin
      longint hs;
      hs = longint'({hdr[49], hdr[50], hdr[51], hdr[52]});
      if (m_7800 && hs != 0 && hs < s) s = hs;
    end
`endif
    return 32'(s);
  endfunction

  task automatic set_hdr_7800(input logic [31:0] sz);
    logic [39:0] m;
    m = "ATARI";
    for (int i = 0; i < HDR_LEN; i++) hdr[i] = 8'(i * 3);
    hdr[1] = m[39:32]; hdr[2] = m[31:24]; hdr[3] = m[23:16];
    hdr[4] = m[15:8];  hdr[5] = m[7:0];
    hdr[49] = sz[31:24]; hdr[50] = sz[23:16]; hdr[51] = sz[15:8]; hdr[52] = sz[7:0];
    hdr[53] = 8'h12; hdr[54] = 8'h34; hdr[55] = 8'h01;
    hdr[56] = 8'h02; hdr[57] = 8'h01; hdr[58] = 8'h02;
  endtask

  task automatic set_hdr_2600();
    for (int i = 0; i < HDR_LEN; i++) hdr[i] = 8'(i * 37 + 11);
  endtask

  // driver tasks
  task automatic begin_load(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    m_active = (idx != 8'd0);
    m_seen   = 1'b0;
    m_last   = '0;
    m_7800   = ({hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]} == 40'h4154415249);
    @(negedge clk_sys);
  endtask

  task automatic send(input logic [24:0] a, input bit last);
    logic [24:0] ea;
    logic [7:0]  d;
    d = byte_at(a);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (last) ioctl_download = 1'b0;
    if (m_active) begin
      ea = (m_7800 && a >= 25'(HDR_LEN)) ? a - 25'(HDR_LEN) : a;
      if (ea < 25'(1 << ADDR_W)) exp_q.push_back({ea[ADDR_W-1:0], d});
      m_last = a;
      m_seen = 1'b1;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input bit end_dl);
    for (int a = lo; a <= hi; a++) send(25'(a), end_dl && (a == hi));
  endtask

  task automatic pause();
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic finish_cart(input string name);
    logic [31:0] es;
    es = model_size();
    pause();
    check({name, "_done_early"}, 32'(load_done), 32'd0);
    @(negedge clk_sys);
    check({name, "_done"}, 32'(load_done), 32'd1);
    check({name, "_size"}, cart_size, es);
    @(negedge clk_sys);
    check({name, "_done_width"}, 32'(load_done), 32'd0);
    check({name, "_run_en"}, 32'(run_en), 32'd1);
    m_active = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_mem_we"}, 32'(mem_we), 32'd0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, "_mem_data"}, 32'(mem_data), 32'd0);
    check({name, "_is_7800"}, 32'(cart_is_7800), 32'd0);
    check({name, "_flags"}, 32'(cart_flags), 32'd0);
    check({name, "_joy"}, {16'd0, joy0_type, joy1_type}, 32'd0);
    check({name, "_region_save"}, {16'd0, cart_region, cart_save}, 32'd0);
    check({name, "_size"}, cart_size, 32'd0);
    check({name, "_overflow"}, 32'(overflow), 32'd0);
    check({name, "_load_done"}, 32'(load_done), 32'd0);
    check({name, "_run_en"}, 32'(run_en), 32'd0);
    check({name, "_state"}, 32'(load_state), 32'(IDLE));
  endtask

  // compare process: every RAM write must match the model's next expected write
  initial begin
    forever begin
      @(negedge clk_sys);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_we_unexpected: got addr %h data %h expected no write", mem_addr, mem_data);
        end else begin
          check("mem_write", {6'd0, mem_addr, mem_data}, {6'd0, exp_q.pop_front()});
        end
      end
      if (load_done) n_done++;
    end
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_wr       = 1'b0;
    m_active       = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_zero("rst");
    reset = 1'b0;

    // BIOS download: ignored entirely
    set_hdr_2600();
    begin_load(8'd0);
    send_range(0, 4095, 1'b1);
    repeat (3) begin
      pause();
      check("bios_no_done", 32'(load_done), 32'd0);
    end
    check("bios_run_en", 32'(run_en), 32'd0);

    // 7800 image: header + 32 KiB payload
    set_hdr_7800(32'd16384);
    begin_load(8'd1);
    send_range(0, 5, 1'b0);
    pause();
    check("a_is_7800_after_b5", 32'(cart_is_7800), 32'd1);
    send_range(6, HDR_LEN + 32767, 1'b1);
    finish_cart("a");
    check("a_size_lit", cart_size, A_SIZE);
    check("a_flags", 32'(cart_flags), 32'h1234);
    check("a_joy0", 32'(joy0_type), 32'd1);
    check("a_joy1", 32'(joy1_type), 32'd2);
    check("a_region", 32'(cart_region), 32'd1);
    check("a_save", 32'(cart_save), 32'd2);
    check("a_overflow", 32'(overflow), 32'd0);

    // 2600 image: no magic, no offset
    set_hdr_2600();
    begin_load(8'd2);
    send_range(0, 5, 1'b0);
    pause();
    check("b_is_7800", 32'(cart_is_7800), 32'd0);
    send_range(6, 4095, 1'b1);
    finish_cart("b");
    check("b_size_lit", cart_size, 32'd4096);
    check("b_flags", 32'(cart_flags), {16'd0, hdr[53], hdr[54]});
    check("b_joy", {16'd0, joy0_type, joy1_type}, {16'd0, hdr[55], hdr[56]});
    check("b_region_save", {16'd0, cart_region, cart_save}, {16'd0, hdr[57], hdr[58]});
    check("b_overflow", 32'(overflow), 32'd0);

    // 7800 image running past the RAM window
    set_hdr_7800(32'd0);
    begin_load(8'd1);
    send_range(0, HDR_LEN + 255, 1'b0);
    send_range(HDR_LEN + 262144 - 4, HDR_LEN + 262144 + 3, 1'b1);
    finish_cart("c");
    check("c_overflow", 32'(overflow), 32'd1);
    check("c_size_lit", cart_size, 32'd262148);

    // reset in the middle of a load, download left high
    set_hdr_7800(32'd0);
    begin_load(8'd1);
    send_range(0, 999, 1'b0);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    reset    = 1'b1;
    m_active = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    check_zero("d_reset");
    send_range(1000, 1015, 1'b0);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      check("d_no_done", 32'(load_done), 32'd0);
    end
    check("d_run_en", 32'(run_en), 32'd0);

    // clean reload after the abandoned one
    begin_load(8'd1);
    send_range(0, HDR_LEN + 8191, 1'b1);
    finish_cart("e");
    check("e_size_lit", cart_size, 32'd8192);
    check("e_is_7800", 32'(cart_is_7800), 32'd1);
    check("e_flags", 32'(cart_flags), 32'h1234);

    repeat (2) @(negedge clk_sys);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(n_done), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/a78_cart_loader.md
# a78_cart_loader

Cartridge download front end between the HPS ioctl stream and the cartridge dual-port RAM. It consumes ioctl bytes for non-BIOS indices and detects and decodes the 128-byte A78 header. It generates the header-stripped RAM write stream, computes the final cartridge size, and releases the console's power-on pause after the first completed cart load.

## Interface
- ADDR_W, default 18: cart RAM address width; writes at or above 2^ADDR_W are dropped.
- HDR_LEN, default 128: A78 header length in bytes.
- clk_sys, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high; one clock; polarity and synchronicity fixed.
- ioctl_download, input, 1: download active.
- ioctl_index, input, 8: 0 = BIOS (ignored by this block), else cart.
- ioctl_addr, input, 25: byte address within file.
- ioctl_dout, input, 8: byte data.
- ioctl_wr, input, 1: byte strobe, one cycle.
- mem_addr, output, ADDR_W: RAM write address.
- mem_data, output, 8: RAM write data.
- mem_we, output, 1: RAM write enable, one cycle per accepted byte.
- cart_is_7800, output, 1: header bytes 1..5 equal "ATARI".
- cart_flags, output, 16: header bytes 53 (high) and 54 (low).
- joy0_type, output, 8: header byte 55.
- joy1_type, output, 8: header byte 56.
- cart_region, output, 8: header byte 57.
- cart_save, output, 8: header byte 58.
- cart_size, output, 32: payload bytes of the last completed load.
- overflow, output, 1: at least one byte was dropped for exceeding ADDR_W.
- load_done, output, 1: one-cycle pulse when a cart load completes.
- run_en, output, 1: 0 until the first load_done, then 1 (sticky).

## Operation
- FSM states:
  - IDLE to HEADER: cart download rises, i.e. ioctl_download & ioctl_index≠0.
  - HEADER to BODY: first accepted write with ioctl_addr ≥ HDR_LEN.
  - HEADER or BODY to FINISH: cart download falls.
  - FINISH to IDLE: unconditional after one cycle.
- Entry to HEADER clears the following: the "ATARI" match bits, cart_flags, joy types, region, save, overflow, last_addr, and seen flag.
- Header match:
  - Five per-byte match flags are captured at addr 1..5.
  - cart_is_7800 = AND of the five flags, registered. It is valid from the cycle after byte 5.
- Header field capture happens in any state when a write has addr < HDR_LEN. It is not tied to cart_is_7800. A 2600 image therefore captures whatever bytes it has there, and downstream qualifies the fields with cart_is_7800.
- Write address:
  - Addr ≥ HDR_LEN and cart_is_7800: mem_addr = addr − HDR_LEN.
  - Otherwise: mem_addr = addr[ADDR_W-1:0].
  - For a 7800 image, header bytes land at 0..127 and are overwritten by payload later. This is intended.
- Address ≥ 2^ADDR_W after offset: mem_we suppressed and overflow set.
- last_addr latches ioctl_addr on every accepted write, and seen is set on the first write.
- FINISH computes cart_size:
  - seen = 0: cart_size = 0.
  - Otherwise: cart_size = last_addr + 1 − (cart_is_7800 ? HDR_LEN : 0), saturating at 0.
  - Arithmetic is 32-bit, with last_addr zero-extended.
- load_done pulses in FINISH. run_en sets on the same cycle.
- BIOS downloads (index 0) produce no mem_we and no state change.
- Reset:
  - FSM goes to IDLE.
  - All outputs go to 0, including run_en and cart_size.
  - A download in progress is abandoned, with no load_done. Loading resumes only on the next rising edge of a cart download.

## Timing
- mem_addr, mem_data and mem_we are registered, one cycle after ioctl_wr.
- Header fields update one cycle after their byte's ioctl_wr.
- load_done asserts 2 cycles after ioctl_download falls: one cycle to detect the edge, one in FINISH. cart_size is stable from that same cycle.
- ioctl_wr coinciding with the falling edge of ioctl_download is still accepted and counted.
- A rising edge of a new download in FINISH is taken on the following cycle from IDLE. No byte is lost, because HDR entry does not gate writes.

## Configuration
- A78_HDR_SIZE_EN:
  - When defined, header bytes 49..52 (big-endian) are captured as hdr_size.
  - In FINISH, when cart_is_7800 and hdr_size≠0, cart_size = min(hdr_size, computed size).
  - When undefined, bytes 49..52 are ignored and cart_size is always the computed size.

## Structure
- Package a78_pkg holds:
  - Header offset localparams: MAGIC_LO=1, MAGIC_HI=5, SIZE_B0=49, FLAGS_HI=53, FLAGS_LO=54, JOY0=55, JOY1=56, REGION=57, SAVE=58.
  - The magic string "ATARI".
  - The loader state enum (IDLE, HEADER, BODY, FINISH).
- Sub-module a78_hdr_parse: the header capture and magic match, driven by the write strobe, address and data. The top-level module keeps the FSM, address generation and size arithmetic.

## Test plan
- 7800 image, 128-byte header "ATARI" plus 32768 bytes of payload:
  - mem_addr 0..32767 for the payload.
  - cart_is_7800 = 1 and cart_size = 32768.
  - load_done pulses once and run_en = 1.
- 2600 image of 4096 bytes with no magic: cart_is_7800 = 0, mem_addr = ioctl_addr, cart_size = 4096.
- Header bytes 53..58 = 12 34 01 02 01 02: cart_flags = 0x1234, joy0_type = 1, joy1_type = 2, region = 1, save = 2.
- 7800 image whose payload exceeds 256 KiB: no mem_we for addr − 128 ≥ 262144, and overflow = 1.
- BIOS download (index 0) of 4096 bytes: mem_we never asserts, run_en stays 0, and no load_done.
- Reset asserted at byte 1000 of a cart load:
  - All outputs read 0 and there is no load_done.
  - A reload then completes normally.
  - With A78_HDR_SIZE_EN and hdr_size = 16384 on a 32768-byte payload, cart_size = 16384.
